// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared widths, op/state encodings and magnitude helper for the mult/div engine
package muldiv_sequencer_pkg;
  localparam int N_BITS = 32;
  localparam int N_MDOP = 3;
  localparam int N_CNT = 6;
  typedef enum logic [N_MDOP-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_SIGN
  } md_state_e;
  function automatic logic [N_BITS-1:0] md_abs(input logic [N_BITS-1:0] v);
    return v[N_BITS-1] ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the EX stage and the mult/div engine
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;
  logic start_i;
  logic flush_i;
  logic [N_MDOP-1:0] md_op_i;
  logic [N_BITS-1:0] a_i;
  logic [N_BITS-1:0] b_i;
  logic busy_o;
  logic done_o;
  logic [N_BITS-1:0] hi_o;
  logic [N_BITS-1:0] lo_o;
  modport master (output start_i, flush_i, md_op_i, a_i, b_i, input busy_o, done_o, hi_o, lo_o);
  modport slave (input start_i, flush_i, md_op_i, a_i, b_i, output busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the 2N-bit accumulator
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic                  is_div,
  input  logic [N_BITS-1:0]     op,
  input  logic [2*N_BITS-1:0]   acc,
  output logic [2*N_BITS-1:0]   acc_next
);
  logic [N_BITS:0] sum;
  logic [N_BITS-1:0] rem;
  logic ge;
  assign sum = {1'b0, acc[2*N_BITS-1:N_BITS]} + {1'b0, op & {N_BITS{acc[0]}}};
  assign ge = acc[2*N_BITS-1:N_BITS-1] >= {1'b0, op};
  assign rem = acc[2*N_BITS-2:N_BITS-1] - op;
  assign acc_next = !is_div ? {sum, acc[N_BITS-1:1]}
                  : ge ? {rem, acc[N_BITS-2:0], 1'b1}
                  : {acc[2*N_BITS-2:0], 1'b0};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input logic clk_i,
  input logic reset_n_i,
  muldiv_sequencer_if.slave md
);
  md_state_e state_q, state_d;
  logic [N_CNT-1:0] cnt;
  logic [N_BITS-1:0] op, a_mag, b_mag, hi_res, lo_res;
  logic [2*N_BITS-1:0] acc, acc_next, prod;
  logic is_div, neg_q, neg_r, sgn_in, div_in, arith, accept, last, commit;
  assign sgn_in = md.md_op_i == MD_MULT || md.md_op_i == MD_DIV;
  assign div_in = md.md_op_i == MD_DIV || md.md_op_i == MD_DIVU;
  assign arith = md.md_op_i inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign accept = state_q == MD_IDLE && md.start_i && !md.flush_i;
  assign last = cnt == N_CNT'(N_BITS - 1);
  assign commit = state_q == MD_SIGN && !md.flush_i;
  assign a_mag = sgn_in ? md_abs(md.a_i) : md.a_i;
  assign b_mag = sgn_in ? md_abs(md.b_i) : md.b_i;
  assign md.busy_o = state_q != MD_IDLE;
  muldiv_step u_step (.is_div(is_div), .op(op), .acc(acc), .acc_next(acc_next));
  always_comb begin
    state_d = md.flush_i ? MD_IDLE
            : state_q == MD_CALC ? (last ? MD_SIGN : MD_CALC)
            : accept && arith ? MD_CALC : MD_IDLE;
    prod = neg_q ? -acc : acc;
    hi_res = is_div ? (neg_r ? -acc[2*N_BITS-1:N_BITS] : acc[2*N_BITS-1:N_BITS]) : prod[2*N_BITS-1:N_BITS];
    lo_res = is_div ? (neg_q ? -acc[N_BITS-1:0] : acc[N_BITS-1:0]) : prod[N_BITS-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= MD_IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt <= '0;
      md.done_o <= 1'b0;
      md.hi_o <= '0;
      md.lo_o <= '0;
    end else begin
      cnt <= state_q == MD_CALC ? cnt + 1'b1 : '0;
      md.done_o <= commit;
      if (commit) begin
        md.hi_o <= hi_res;
        md.lo_o <= lo_res;
      end
      if (accept && md.md_op_i == MD_MTHI) md.hi_o <= md.a_i;
      if (accept && md.md_op_i == MD_MTLO) md.lo_o <= md.a_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept && arith) begin
      is_div <= div_in;
      op <= div_in ? b_mag : a_mag;
      acc <= {{N_BITS{1'b0}}, div_in ? a_mag : b_mag};
      neg_q <= sgn_in && (md.a_i[N_BITS-1] ^ md.b_i[N_BITS-1]) && !(div_in && md.b_i == '0);
      neg_r <= sgn_in && div_in && md.a_i[N_BITS-1];
    end else if (state_q == MD_CALC) begin
      acc <= acc_next;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of the mult/div sequencer against an arithmetic model
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  muldiv_sequencer_if mif();
  muldiv_sequencer dut (.clk_i(clk), .reset_n_i(rst_n), .md(mif));
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    if (op == MD_MULT) return 64'(sa * sb);
    if (op == MD_MULTU) return 64'(ua * ub);
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (op == MD_DIV) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n;
    int busy_n;
    e = model(op, a, b);
    n = 0;
    busy_n = 0;
    mif.start_i = 1'b1;
    mif.md_op_i = op;
    mif.a_i = a;
    mif.b_i = b;
    tick;
    mif.start_i = 1'b0;
    mif.a_i = $urandom;
    mif.b_i = $urandom;
    check("busy_after_accept", 32'(mif.busy_o), 1);
    while (!mif.done_o && n < 40) begin
      busy_n += int'(mif.busy_o);
      tick;
      n++;
    end
    check("latency", n, N_BITS + 1);
    check("busy_cycles", busy_n, N_BITS + 1);
    check("busy_at_done", 32'(mif.busy_o), 0);
    check("hi", mif.hi_o, e[63:32]);
    check("lo", mif.lo_o, e[31:0]);
  endtask

  task automatic spec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] hi, input logic [31:0] lo);
    run_op(op, a, b);
    check("spec_hi", mif.hi_o, hi);
    check("spec_lo", mif.lo_o, lo);
  endtask

  initial begin
    logic [31:0] h0, l0, ra, rb;
    logic [2:0] rop;
    logic saw_done;
    mif.start_i = 1'b0;
    mif.flush_i = 1'b0;
    mif.md_op_i = 3'd0;
    mif.a_i = 32'h0;
    mif.b_i = 32'h0;
    repeat (3) tick;
    check("rst_busy", 32'(mif.busy_o), 0);
    check("rst_done", 32'(mif.done_o), 0);
    check("rst_hi", mif.hi_o, 0);
    check("rst_lo", mif.lo_o, 0);
    rst_n = 1'b1;
    tick;
    spec(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    tick;
    check("done_pulse", 32'(mif.done_o), 0);
    check("hi_hold", mif.hi_o, 32'hFFFFFFFE);
    spec(MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    spec(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    spec(MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    spec(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    spec(MD_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    tick;
    h0 = mif.hi_o;
    l0 = mif.lo_o;
    mif.start_i = 1'b1;
    mif.md_op_i = MD_MULT;
    mif.a_i = 32'h12345;
    mif.b_i = 32'h777;
    tick;
    mif.start_i = 1'b0;
    repeat (4) tick;
    mif.start_i = 1'b1;
    mif.md_op_i = MD_MTHI;
    mif.a_i = 32'hDEAD;
    tick;
    mif.start_i = 1'b0;
    check("busy_ignore_start", 32'(mif.busy_o), 1);
    repeat (4) tick;
    mif.flush_i = 1'b1;
    tick;
    mif.flush_i = 1'b0;
    check("flush_busy", 32'(mif.busy_o), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_done |= mif.done_o;
      tick;
    end
    check("flush_no_done", 32'(saw_done), 0);
    check("flush_hi", mif.hi_o, h0);
    check("flush_lo", mif.lo_o, l0);
    mif.start_i = 1'b1;
    mif.md_op_i = MD_MTLO;
    mif.a_i = 32'hBEEF;
    mif.flush_i = 1'b1;
    tick;
    mif.start_i = 1'b0;
    mif.flush_i = 1'b0;
    check("idle_flush_lo", mif.lo_o, l0);
    check("idle_flush_busy", 32'(mif.busy_o), 0);
    mif.start_i = 1'b1;
    mif.md_op_i = MD_MTHI;
    mif.a_i = 32'h1234;
    tick;
    check("mthi_hi", mif.hi_o, 32'h1234);
    check("mthi_busy", 32'(mif.busy_o), 0);
    mif.md_op_i = MD_MTLO;
    mif.a_i = 32'h5678;
    tick;
    mif.start_i = 1'b0;
    check("mtlo_lo", mif.lo_o, 32'h5678);
    check("mtlo_hi", mif.hi_o, 32'h1234);
    check("mtlo_busy", 32'(mif.busy_o), 0);
    check("mtlo_done", 32'(mif.done_o), 0);
    mif.start_i = 1'b1;
    mif.md_op_i = MD_DIVU;
    mif.a_i = 32'h9999;
    mif.b_i = 32'h7;
    tick;
    mif.start_i = 1'b0;
    repeat (20) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrst_busy", 32'(mif.busy_o), 0);
    check("midrst_done", 32'(mif.done_o), 0);
    check("midrst_hi", mif.hi_o, 0);
    check("midrst_lo", mif.lo_o, 0);
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 | $urandom : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(rop, ra, rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
